// File: rtl/conv_window_reader_pkg.sv
// Shared definitions for the convolution window reader: kernel geometry,
// FSM state encoding and the tap-index to window-offset mapping.
package conv_pkg;

  localparam int unsigned KSIZE = 3;
  localparam int unsigned KTAPS = KSIZE * KSIZE;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OUT,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0] di;
    logic [1:0] dj;
  } tap_off_t;

  // Tap k of a row-major 3x3 window sits at (k/3, k%3) from its top-left pixel.
  function automatic tap_off_t tap_offset(input logic [3:0] k);
    tap_off_t o;
    o.di = 2'(k / 4'(KSIZE));
    o.dj = 2'(k % 4'(KSIZE));
    return o;
  endfunction

endpackage

// File: rtl/conv_window_reader_if.sv
// RAM read port and window output stream of the convolution window reader.
interface conv_window_reader_if
  import conv_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 10
);

  logic                 ram_rd;
  logic [M-1:0]         ram_adr;
  logic [N-1:0]         ram_data;
  logic                 win_valid;
  logic                 win_ready;
  logic [KTAPS*N-1:0]   win_data;
  logic [M-1:0]         out_row;
  logic [M-1:0]         out_col;

  modport master (
    output ram_rd, ram_adr, win_valid, win_data, out_row, out_col,
    input  ram_data, win_ready
  );

  modport slave (
    input  ram_rd, ram_adr, win_valid, win_data, out_row, out_col,
    output ram_data, win_ready
  );

endinterface

// File: rtl/conv_window_reader_win_addr_gen.sv
// Window position / tap counters and the RAM address multiply-add for the
// tap currently being fetched.
module win_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned M = 10,
  parameter int unsigned P = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic         advance,
  output logic [M-1:0] row,
  output logic [M-1:0] col,
  output logic [M-1:0] adr,
  output logic [3:0]   k,
  output logic         last_tap,
  output logic         last_win
);

  localparam logic [M-1:0] PM   = M'(P);
  localparam logic [M-1:0] EDGE = M'(P - KSIZE);

  tap_off_t     off;
  logic [M-1:0] tap_row;

  always_comb begin
    off      = tap_offset(k);
    tap_row  = row + M'(off.di);
    adr      = tap_row * PM + col + M'(off.dj);
    last_tap = (k == 4'(KTAPS - 1));
    last_win = (row == EDGE) && (col == EDGE);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
      k   <= '0;
    end else begin
      if (step) begin
        k <= last_tap ? '0 : k + 4'd1;
      end
      if (advance) begin
        k <= '0;
        if (col == EDGE) begin
          col <= '0;
          row <= row + M'(1);
        end else begin
          col <= col + M'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Sweeps a 3x3 window over a PxP image held in RAM, fetching nine pixels per
// position and presenting the packed window over a valid/ready handshake.
module conv_window_reader
  import conv_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 10,
  parameter int unsigned P = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  conv_window_reader_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  state_t       state;
  logic [M-1:0] row;
  logic [M-1:0] col;
  logic [M-1:0] adr;
  logic [3:0]   k;
  logic         last_tap;
  logic         last_win;
  logic         clear;
  logic         step;
  logic         accept;
  logic         advance;

  always_comb begin
    clear   = (state == IDLE) && start;
    step    = (state == FETCH);
    accept  = (state == OUT) && bus.win_ready;
    advance = accept && !last_win;
  end

  win_addr_gen #(
    .M (M),
    .P (P)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .step     (step),
    .advance  (advance),
    .row      (row),
    .col      (col),
    .adr      (adr),
    .k        (k),
    .last_tap (last_tap),
    .last_win (last_win)
  );

  // ram_rd is a registered FETCH flag; the address follows the live tap counter.
  assign bus.ram_adr = bus.ram_rd ? adr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.ram_rd    <= 1'b0;
      bus.win_valid <= 1'b0;
      bus.win_data  <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FETCH;
            bus.ram_rd <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          for (int unsigned t = 0; t < KTAPS; t++) begin
            if (k == 4'(t)) bus.win_data[N*t +: N] <= bus.ram_data;
          end
          if (last_tap) begin
            state         <= OUT;
            bus.ram_rd    <= 1'b0;
            bus.win_valid <= 1'b1;
            bus.out_row   <= row;
            bus.out_col   <= col;
          end
        end
        OUT: begin
          if (bus.win_ready) begin
            bus.win_valid <= 1'b0;
            if (last_win) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= FETCH;
              bus.ram_rd <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader: P=28 and P=4 instances fed by
// behavioural RAMs, checked against hand values and a pixel-formula model.
module tb_conv_window_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [16];

  int n_cmp = 0;
  int n_err = 0;
  int er, ec, nwin;
  bit done_seen;

  always #5 clk = ~clk;

  conv_window_reader_if #(.N(8), .M(10)) bus_a ();
  conv_window_reader_if #(.N(8), .M(4))  bus_b ();

  assign bus_a.ram_data = mem_a[bus_a.ram_adr];
  assign bus_b.ram_data = mem_b[bus_b.ram_adr];

  conv_window_reader #(.N(8), .M(10), .P(28)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .bus   (bus_a.master),
    .busy  (busy_a),
    .done  (done_a)
  );

  conv_window_reader #(.N(8), .M(4), .P(4)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .bus   (bus_b.master),
    .busy  (busy_b),
    .done  (done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] win_exp(input int r, input int c, input int p);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(((r + i) * p + c + j) % 256);
    return w;
  endfunction

  task automatic check_reset_a(input string tag);
    check({tag, "_ram_rd"},    bus_a.ram_rd,    1'b0);
    check({tag, "_ram_adr"},   bus_a.ram_adr,   10'd0);
    check({tag, "_win_valid"}, bus_a.win_valid, 1'b0);
    check({tag, "_win_data"},  bus_a.win_data,  72'd0);
    check({tag, "_out_row"},   bus_a.out_row,   10'd0);
    check({tag, "_out_col"},   bus_a.out_col,   10'd0);
    check({tag, "_busy"},      busy_a,          1'b0);
    check({tag, "_done"},      done_a,          1'b0);
  endtask

  // Runs DUT A until done, checking every presented window against the model.
  task automatic scan_a(input bit rnd, input int poke_at, input int budget);
    logic [71:0] held;
    bit held_v;
    bit rdy;
    held_v = 1'b0;
    held = '0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_a.win_ready = rdy;
      start_a = (cyc == poke_at);
      if (held_v) check("held_data", bus_a.win_data, held);
      if (bus_a.win_valid) begin
        check("win_data", bus_a.win_data, win_exp(er, ec, 28));
        check("win_pos", {bus_a.out_row, bus_a.out_col}, {10'(er), 10'(ec)});
        if (rdy) begin
          held_v = 1'b0;
          nwin++;
          if (ec == 25) begin ec = 0; er++; end
          else ec++;
        end else begin
          held_v = 1'b1;
          held = bus_a.win_data;
        end
      end else begin
        held_v = 1'b0;
      end
      tick();
      if (done_a) done_seen = 1'b1;
    end
    start_a = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("win_count", nwin, 676);
  endtask

  initial begin
    int br, bc, bn;
    for (int a = 0; a < 1024; a++) mem_a[a] = 8'(a % 256);
    for (int a = 0; a < 16; a++) mem_b[a] = 8'(a);
    bus_a.win_ready = 1'b1;
    bus_b.win_ready = 1'b1;

    tick(); tick();
    rst = 1'b0;
    check_reset_a("reset");
    tick();
    check("idle_busy", busy_a, 1'b0);

    // First window latency and address sequence.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("fetch_busy", busy_a, 1'b1);
    check("fetch_rd", bus_a.ram_rd, 1'b1);
    check("adr_k0", bus_a.ram_adr, 10'd0);
    tick();
    check("adr_k1", bus_a.ram_adr, 10'd1);
    tick(); tick();
    check("adr_k3", bus_a.ram_adr, 10'd28);
    repeat (5) tick();
    check("adr_k8", bus_a.ram_adr, 10'd58);
    check("valid_early", bus_a.win_valid, 1'b0);
    tick();
    check("first_valid", bus_a.win_valid, 1'b1);
    check("first_data", bus_a.win_data, 72'h3A39381E1D1C020100);
    check("first_row", bus_a.out_row, 10'd0);
    check("first_col", bus_a.out_col, 10'd0);
    check("out_rd", bus_a.ram_rd, 1'b0);
    check("out_adr", bus_a.ram_adr, 10'd0);

    // Accept (0,0), then backpressure window (0,1).
    tick();
    bus_a.win_ready = 1'b0;
    check("accept_valid", bus_a.win_valid, 1'b0);
    check("refetch_adr", bus_a.ram_adr, 10'd1);
    repeat (9) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus_a.win_valid, 1'b1);
      check("bp_data", bus_a.win_data, 72'h3B3A391F1E1D030201);
      check("bp_col", bus_a.out_col, 10'd1);
      check("bp_rd", bus_a.ram_rd, 1'b0);
      tick();
    end
    bus_a.win_ready = 1'b1;
    tick();
    check("post_bp_valid", bus_a.win_valid, 1'b0);
    check("post_bp_rd", bus_a.ram_rd, 1'b1);
    check("post_bp_adr", bus_a.ram_adr, 10'd2);

    // Remainder of scan 1, with a start pulse while busy.
    er = 0; ec = 2; nwin = 2;
    scan_a(1'b0, 30, 20000);
    check("done_pulse", done_a, 1'b1);
    check("done_busy", busy_a, 1'b0);
    check("last_data", bus_a.win_data, 72'h0F0E0DF3F2F1D7D6D5);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("done_clear", done_a, 1'b0);
    check("done_start_busy", busy_a, 1'b0);
    tick();
    check("still_idle_busy", busy_a, 1'b0);
    check("still_idle_rd", bus_a.ram_rd, 1'b0);

    // Scan 2: random win_ready over a full scan.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    er = 0; ec = 0; nwin = 0;
    scan_a(1'b1, -1, 40000);
    tick();

    // Reset during FETCH k=4 of window (3,7).
    bus_a.win_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (854) tick();
    check("mid_fetch_adr", bus_a.ram_adr, 10'd120);
    check("mid_fetch_busy", busy_a, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_a("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", done_a, 1'b0);
      check("midrst_idle", busy_a, 1'b0);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    check("restart_valid", bus_a.win_valid, 1'b1);
    check("restart_data", bus_a.win_data, 72'h3A39381E1D1C020100);
    check("restart_pos", {bus_a.out_row, bus_a.out_col}, 20'd0);

    // P=4 instance: four windows in row-major order, out_col wraps 1 -> 0.
    bn = 0; br = 0; bc = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_b; cyc++) begin
      if (bus_b.win_valid) begin
        check("p4_pos", {bus_b.out_row, bus_b.out_col}, {4'(br), 4'(bc)});
        check("p4_data", bus_b.win_data, win_exp(br, bc, 4));
        bn++;
        if (bc == 1) begin bc = 0; br++; end
        else bc++;
      end
      tick();
    end
    check("p4_done", done_b, 1'b1);
    check("p4_count", bn, 4);
    tick();
    check("p4_done_clear", done_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_reader.md
# conv_window_reader

Read-side companion to the image buffer RAM in the convolution accelerator. After the RAM has been filled with a P×P image, this block sweeps a 3×3 window across it in row-major order. For each output position it issues nine sequential reads, gathers the pixels into one 9-pixel word, and hands that word to the 9-multiplier datapath over a valid/ready handshake.

## Interface
- `N`, default 8: pixel width; must equal the RAM data width.
- `M`, default 10: RAM address width; P*P ≤ 2**M required.
- `P`, default 28: image side length in pixels; P ≥ 3.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle request to scan the buffered image; typically driven from the RAM `full` flag.
- `ram_rd`, out, 1: RAM read enable.
- `ram_adr`, out, M: RAM read address.
- `ram_data`, in, N: RAM read data; combinational from `ram_adr` while `ram_rd`=1.
- `win_valid`, out, 1: `win_data` holds a complete window.
- `win_ready`, in, 1: consumer accepts the window.
- `win_data`, out, 9*N: window; slice `[N*(3*i+j) +: N]` = pixel(row+i, col+j).
- `out_row`, out, M: top-left row of the presented window.
- `out_col`, out, M: top-left column of the presented window.
- `busy`, out, 1: a scan is in progress.
- `done`, out, 1: one-cycle pulse after the last window is accepted.

## Operation
- FSM states: IDLE, FETCH, OUT, DONE.
- IDLE:
  - `start`=1 → FETCH, with row=col=0 and k=0.
  - `start` is ignored in every other state.
- FETCH:
  - `ram_rd`=1 and `ram_adr` = (row+k/3)*P + col + k%3, computed in M bits.
  - At each edge, `ram_data` is stored into slot k and k increments.
  - After slot 8 is captured → OUT.
- OUT:
  - `win_valid`=1; `win_data`, `out_row` and `out_col` are held stable until accepted.
  - Handshake completes at an edge where `win_valid` & `win_ready` = 1.
  - On accept at row=col=P-3 → DONE.
  - Otherwise: col+1; if col was P-3, then col=0 and row+1. k=0, → FETCH.
- DONE: `done`=1 for one cycle, then → IDLE.
- `busy` = 1 in FETCH and OUT.
- `ram_rd` = 0 and `ram_adr` = 0 outside FETCH.
- Windows per scan: (P-2)²; 676 for P=28.

## Timing
- Reset values: `ram_rd`=0, `ram_adr`=0, `win_valid`=0, `win_data`=0, `out_row`=0, `out_col`=0, `busy`=0, `done`=0; state = IDLE.
- `start` sampled high at edge t → FETCH from t+1 → first `win_valid` at t+10.
- Each window costs 9 FETCH cycles plus at least 1 OUT cycle, so steady state is 10 cycles per window when `win_ready` is held at 1.
- `win_ready` high before `win_valid` is legal. The window is accepted on the first OUT cycle.
- `rst` asserted in any state, including mid-FETCH or in OUT with the window not yet accepted:
  - the next edge returns the block to IDLE with all reset values;
  - no `done` pulse is produced;
  - the partial window is discarded.
- `start` arriving in the same cycle as `done` is ignored. A new scan needs `start` while in IDLE.

## Structure
- Shared package `conv_pkg` holds:
  - `KSIZE`=3 and `KTAPS`=9;
  - the FSM state enum;
  - a function packing a tap index to its (di, dj) offsets.
- Natural sub-module: `win_addr_gen`, holding the row/col/k counters and the address multiply-add. The FSM and window register stay in the top block.

## Test plan
- P=28, N=8, RAM preloaded with mem[a] = a mod 256, pulse `start`, `win_ready`=1:
  - first window at t+10 is {0,1,2,28,29,30,56,57,58}, with `out_row`=`out_col`=0;
  - last window at (25,25) is {213,214,215,241,242,243,13,14,15};
  - exactly 676 windows, then a single `done` pulse.
- Backpressure: hold `win_ready`=0 for 5 cycles on window (0,1) → `win_data` stays {1,2,3,29,30,31,57,58,59}, `ram_rd`=0, and the next FETCH starts the cycle after accept.
- P=4: windows (0,0), (0,1), (1,0), (1,1) in that order, then `done`. `out_col` wraps from 1 to 0.
- `rst` asserted during FETCH k=4 of window (3,7) → the next cycle shows every output at its reset value and IDLE. A fresh `start` restarts from (0,0).
- `start` pulsed while `busy`=1, and again on the `done` cycle → both ignored, window count still 676.
- Random `win_ready` toggling over a full scan → scoreboard matches a reference model for all 676 windows; `win_data` never changes while `win_valid`=1 and `win_ready`=0.
